// File: rtl/tt_um_serial_adder.sv
// Bit-serial adder/subtractor: byte-loaded operands are combined one bit per
// enabled clock, LSB first, into a result register read back one byte at a time.
module tt_um_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IDXW   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_r;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_sub;
    logic              r_busy;
    logic              r_done;
    logic              r_zero;

    logic              w_load_a;
    logic              w_load_b;
    logic              w_start;
    logic              w_sub;
    logic              w_bit_a;
    logic              w_bit_b;
    logic              w_sum;
    logic              w_cout;
    logic [WIDTH-1:0]  w_r_next;
    logic [1:0]        w_sel;
    logic [31:0]       w_r_ext;
    logic              w_unused;

    assign w_load_a = uio_in[4];
    assign w_load_b = uio_in[5];
    assign w_start  = uio_in[6];
    assign w_sub    = uio_in[7];
    assign w_unused = ^uio_in[3:0];

    // One full-adder slice; subtraction inverts B and seeds the carry with 1.
    assign w_bit_a  = r_a[r_idx];
    assign w_bit_b  = r_b[r_idx] ^ r_sub;
    assign w_sum    = w_bit_a ^ w_bit_b ^ r_carry;
    assign w_cout   = (w_bit_a & w_bit_b) | (w_bit_a & r_carry) | (w_bit_b & r_carry);
    assign w_r_next = {w_sum, r_r[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_sub   <= w_sub;
                        r_idx   <= '0;
                        r_carry <= w_sub;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_zero  <= 1'b0;
                    end else begin
                        if (w_load_a) r_a <= WIDTH'({r_a, ui_in});
                        if (w_load_b) r_b <= WIDTH'({r_b, ui_in});
                    end
                end
                S_RUN: begin
                    r_r     <= w_r_next;
                    r_carry <= w_cout;
                    if (r_idx == IDXW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_zero  <= (w_r_next == '0);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_zero  <= 1'b0;
                end
            endcase
        end
    end

    // Byte readout; bytes above the operand width read as zero.
    assign w_sel   = ui_in[1:0];
    assign w_r_ext = 32'(r_r);

    always_comb begin
        uo_out = 8'h00;
        if (32'(w_sel) < NBYTES) begin
            uo_out = w_r_ext[{w_sel, 3'b000} +: 8];
        end
    end

    assign uio_out = {4'b0000, r_zero, r_carry, r_done, r_busy};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Directed and randomized checks of the serial adder against an arithmetic model.
module tb_tt_um_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_sub;

    tt_um_serial_adder #(.WIDTH(WIDTH)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shift a 16-bit value in MSB byte first to A, B or both.
    task automatic load(input bit la, input bit lb, input logic [15:0] v);
        for (int i = 1; i >= 0; i--) begin
            ui_in  = v[8*i +: 8];
            uio_in = {2'b00, lb, la, 4'b0000};
            tick();
            if (la) m_a = {m_a[7:0], v[8*i +: 8]};
            if (lb) m_b = {m_b[7:0], v[8*i +: 8]};
        end
        uio_in = 8'h00;
    endtask

    // Start pulse also carries load requests and junk data that must be ignored.
    task automatic start_op(input bit s);
        ui_in  = 8'hEE;
        uio_in = {s, 1'b1, 2'b11, 4'b1010};
        tick();
        m_sub  = s;
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (uio_out[1] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_r(output logic [15:0] r);
        ui_in = 8'h00; #1; r[7:0]  = uo_out;
        ui_in = 8'h01; #1; r[15:8] = uo_out;
        ui_in = 8'h00; #1;
    endtask

    task automatic check_result(input string tag);
        logic [16:0] sum;
        logic [15:0] exp_r;
        logic        exp_c;
        logic [15:0] r;
        if (m_sub) begin
            exp_r = m_a - m_b;
            exp_c = (m_a >= m_b);
        end else begin
            sum   = {1'b0, m_a} + {1'b0, m_b};
            exp_r = sum[15:0];
            exp_c = sum[16];
        end
        read_r(r);
        check({tag, ".r"}, 32'(r), 32'(exp_r));
        check({tag, ".status"}, 32'(uio_out), 32'({4'b0000, exp_r == 16'h0, exp_c, 2'b10}));
    endtask

    task automatic finish_op(input string tag, input int already, input int exp_cycles);
        int n;
        wait_done(n);
        check({tag, ".cycles"}, 32'(already + n), 32'(exp_cycles));
        check_result(tag);
    endtask

    initial begin
        int          n;
        logic [15:0] r;
        logic [15:0] prev_r;
        logic [7:0]  held_st;
        logic [7:0]  held_uo;

        checks = 0;
        errors = 0;
        m_a = 16'h0; m_b = 16'h0; m_sub = 1'b0;
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

        // Reset acts even with the design disabled.
        tick(); tick();
        check("reset.uio_out", 32'(uio_out), 32'h00);
        check("reset.uo_out", 32'(uo_out), 32'h00);
        check("reset.uio_oe", 32'(uio_oe), 32'h0F);
        rst_n = 1'b1; ena = 1'b1;
        tick();

        // Add: 0x1234 + 0x0FCC, with busy tracked cycle by cycle.
        load(1, 0, 16'h1234);
        load(0, 1, 16'h0FCC);
        start_op(0);
        n = 0;
        while (uio_out[0] === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("add.busy_cycles", 32'(n), 32'd16);
        check_result("add");
        ui_in = 8'h01; #1;
        check("add.byte1", 32'(uo_out), 32'h22);
        ui_in = 8'h02; #1;
        check("add.byte2", 32'(uo_out), 32'h00);
        ui_in = 8'h00;

        // Subtract with borrow.
        load(1, 0, 16'h1234);
        load(0, 1, 16'h1235);
        start_op(1);
        finish_op("sub_borrow", 0, 16);

        // Wrap to zero.
        load(1, 0, 16'hFFFF);
        load(0, 1, 16'h0001);
        start_op(0);
        finish_op("wrap", 0, 16);
        ui_in = 8'h03; #1;
        check("wrap.byte3", 32'(uo_out), 32'h00);
        ui_in = 8'h00;

        // Shared load: A == B, subtract gives zero with no borrow.
        load(1, 1, 16'hA55A);
        start_op(1);
        finish_op("shared_load", 0, 16);

        // Controls pulsed mid-RUN are ignored.
        load(1, 0, 16'h3C0F);
        load(0, 1, 16'h1111);
        start_op(0);
        for (int i = 0; i < 3; i++) tick();
        ui_in  = 8'hAA;
        uio_in = 8'hF0;
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
        finish_op("ignored_ctrl", 4, 16);
        start_op(0);
        finish_op("ignored_ctrl.rerun", 0, 16);

        // ena stall mid-RUN.
        load(1, 0, 16'h7F01);
        load(0, 1, 16'h00FF);
        start_op(0);
        for (int i = 0; i < 4; i++) tick();
        ena = 1'b0;
        held_st = uio_out;
        held_uo = uo_out;
        for (int i = 0; i < 5; i++) tick();
        check("stall.status_hold", 32'(uio_out), 32'(held_st));
        check("stall.result_hold", 32'(uo_out), 32'(held_uo));
        ena = 1'b1;
        finish_op("stall", 9, 21);

        // Reset while processing bit 7.
        load(1, 0, 16'hBEEF);
        load(0, 1, 16'h1234);
        start_op(0);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_a = 16'h0; m_b = 16'h0;
        check("midreset.uio_out", 32'(uio_out), 32'h00);
        check("midreset.uo_out0", 32'(uo_out), 32'h00);
        ui_in = 8'h01; #1;
        check("midreset.uo_out1", 32'(uo_out), 32'h00);
        ui_in = 8'h00;
        start_op(0);
        finish_op("midreset.zero", 0, 16);

        // Randomized operations; loads in DONE must leave R untouched.
        for (int t = 0; t < 24; t++) begin
            logic [15:0] va;
            logic [15:0] vb;
            logic        s;
            read_r(prev_r);
            va = 16'($urandom);
            vb = 16'($urandom);
            s  = 1'($urandom);
            if (t % 6 == 0) vb = va;
            load(1, 0, va);
            load(0, 1, vb);
            read_r(r);
            check("rand.r_hold", 32'(r), 32'(prev_r));
            start_op(s);
            finish_op("rand", 0, 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_adder.md
TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; legal values 8, 16, 24, 32.
REQ-002 The block SHALL derive NBYTES = WIDTH/8, meaning the number of bytes per operand.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning the reset; one clock, reset synchronous and active-low.
REQ-005 The block SHALL have port ena, input, 1 bit, meaning design enable; low freezes all registers.
REQ-006 The block SHALL have port ui_in, input, 8 bits, meaning load data byte; ui_in[1:0] also selects the result byte in DONE.
REQ-007 The block SHALL have port uio_in, input, 8 bits, meaning controls: [4] load_a, [5] load_b, [6] start, [7] sub; [3:0] ignored.
REQ-008 The block SHALL have port uo_out, output, 8 bits, meaning the selected result byte.
REQ-009 The block SHALL have port uio_out, output, 8 bits, meaning status: [0] busy, [1] done, [2] carry, [3] zero; [7:4] = 0.
REQ-010 The block SHALL have port uio_oe, output, 8 bits, meaning pin direction; constant 8'h0F.

Function
REQ-011 The block SHALL hold operand registers A and B, WIDTH bits each, plus result register R, WIDTH bits.
REQ-012 In IDLE or DONE, when load_a=1 and start=0, the block SHALL update A <= {A[WIDTH-9:0], ui_in}, so bytes enter MSB-first; load_b SHALL update B the same way.
REQ-013 When load_a and load_b are both high in the same cycle, both A and B SHALL shift in the same ui_in byte.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE; reset state is IDLE.
REQ-015 A start=1 sampled in IDLE or DONE SHALL latch sub, clear the bit index to 0, set the carry register to sub, and enter RUN; loads in that cycle SHALL be ignored.
REQ-016 In RUN, each enabled cycle i (0..WIDTH-1) SHALL compute s = A[i] ^ b ^ c and c' = majority(A[i], b, c), with b = B[i] ^ sub, and shift s into R from the MSB side.
REQ-017 After the cycle with i = WIDTH-1, the FSM SHALL enter DONE; RUN SHALL last exactly WIDTH enabled cycles.
REQ-018 In RUN, start, load_a and load_b SHALL be ignored; A and B SHALL never be modified by RUN.
REQ-019 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both registered.
REQ-020 carry SHALL hold the final carry-out in DONE; for sub=1 this is 1 when no borrow (A >= B unsigned).
REQ-021 zero SHALL be 1 in DONE iff R == 0, and 0 otherwise.
REQ-022 uo_out SHALL equal R[8*k+7:8*k] with k = ui_in[1:0] when k < NBYTES, and 8'h00 when k >= NBYTES; this path is combinational from ui_in and R.
REQ-023 While ena=0, the state, index, carry, A, B and R SHALL all hold; outputs SHALL reflect the held state.
REQ-024 Results SHALL be modulo 2^WIDTH; no other overflow indication SHALL be provided.

Reset
REQ-025 On rst_n=0 at a clock edge, the block SHALL clear A, B, R, the carry register and the index to 0, and set the state to IDLE, regardless of ena or current state, including mid-RUN.
REQ-026 After reset, the block SHALL drive uo_out=8'h00, uio_out=8'h00 and uio_oe=8'h0F.

Verification
REQ-027 The bench SHALL cover add: WIDTH=16, load_a bytes 0x12 then 0x34, load_b bytes 0x0F then 0xCC, start with sub=0 -> busy for 16 cycles, then done=1, R=0x2200, carry=0, zero=0; ui_in[1:0]=1 -> uo_out=0x22.
REQ-028 The bench SHALL cover subtract with borrow: A=0x1234, B=0x1235, sub=1 -> R=0xFFFF, carry=0, zero=0.
REQ-029 The bench SHALL cover wrap: A=0xFFFF, B=0x0001, sub=0 -> R=0x0000, carry=1, zero=1; ui_in[1:0]=3 -> uo_out=0x00.
REQ-030 The bench SHALL cover ignored controls: start and load_a pulsed mid-RUN -> completion still exactly 16 cycles after the original start, and A unchanged.
REQ-031 The bench SHALL cover ena stall: ena=0 for 5 cycles mid-RUN -> done is asserted 5 cycles late and R is correct.
REQ-032 The bench SHALL cover reset mid-RUN: rst_n=0 at bit 7 -> the next cycle shows IDLE, uio_out=0x00, uo_out=0x00, and a fresh start with A=B=0 gives R=0 and zero=1.
